// File: rtl/bus_master_if.sv
// Per-master bus interface: turns a level-held CPU access strobe into the
// req_/grnt_/as_/rdy_ bus handshake, stalls the stage while in flight, returns read data.
module bus_master_if #(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        cpu_as_,
    input  logic        cpu_rw,
    input  logic [29:0] cpu_addr,
    input  logic [31:0] cpu_wr_data,
    output logic [31:0] cpu_rd_data,
    output logic        busy,
    output logic        err,
    output logic        bus_req_,
    input  logic        bus_grnt_,
    output logic [29:0] bus_addr,
    output logic        bus_as_,
    output logic        bus_rw,
    output logic [31:0] bus_wr_data,
    input  logic [31:0] bus_rd_data,
    input  logic        bus_rdy_
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACCESS = 2'd2,
        WAIT   = 2'd3
    } state_t;

    localparam bit             TO_EN    = (TIMEOUT != 0);
    localparam int             TO_LAST  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_LAST);

    state_t             state_q, state_d;
    logic               req_n_q, req_n_d;
    logic               as_n_q, as_n_d;
    logic               rw_q, rw_d;
    logic [29:0]        addr_q, addr_d;
    logic [31:0]        wr_data_q, wr_data_d;
    logic [31:0]        rd_buf_q, rd_buf_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        done_data;

    always_comb begin
        state_d     = state_q;
        req_n_d     = req_n_q;
        as_n_d      = 1'b1;
        rw_d        = rw_q;
        addr_d      = addr_q;
        wr_data_d   = wr_data_q;
        rd_buf_d    = rd_buf_q;
        err_d       = 1'b0;
        cnt_d       = cnt_q;
        busy        = 1'b0;
        cpu_rd_data = rd_buf_q;
        // Writes return zero so the CPU never sees stale bus data
        done_data   = rw_q ? bus_rd_data : 32'h0;

        case (state_q)
            IDLE: begin
                busy = ~cpu_as_ & ~flush;
                if (!cpu_as_ && !flush) begin
                    addr_d    = cpu_addr;
                    rw_d      = cpu_rw;
                    wr_data_d = cpu_wr_data;
                    req_n_d   = 1'b0;
                    state_d   = REQ;
                end
            end
            REQ: begin
                busy = 1'b1;
                if (flush) begin
                    req_n_d = 1'b1;
                    state_d = IDLE;
                end else if (!bus_grnt_) begin
                    as_n_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                busy = 1'b1;
                if (!bus_rdy_) begin
                    busy        = 1'b0;
                    cpu_rd_data = done_data;
                    rd_buf_d    = done_data;
                    req_n_d     = 1'b1;
                    state_d     = stall ? WAIT : IDLE;
                end else if (TO_EN && cnt_q == CNT_LAST) begin
                    busy        = 1'b0;
                    cpu_rd_data = 32'h0;
                    rd_buf_d    = 32'h0;
                    err_d       = 1'b1;
                    req_n_d     = 1'b1;
                    state_d     = stall ? WAIT : IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT: begin
                if (!stall) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            req_n_q   <= 1'b1;
            as_n_q    <= 1'b1;
            rw_q      <= 1'b1;
            addr_q    <= '0;
            wr_data_q <= '0;
            rd_buf_q  <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            req_n_q   <= req_n_d;
            as_n_q    <= as_n_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            rd_buf_q  <= rd_buf_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus_req_    = req_n_q;
    assign bus_as_     = as_n_q;
    assign bus_rw      = rw_q;
    assign bus_addr    = addr_q;
    assign bus_wr_data = wr_data_q;
    assign err         = err_q;

endmodule

// File: tb/tb_bus_master_if.sv
// Scoreboard bench for bus_master_if: stimulus pushes expected completions,
// a negedge monitor pops and checks whenever the DUT reports one.
module tb_bus_master_if;
    localparam int TMO = 8;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        cpu_as_;
    logic        cpu_rw;
    logic [29:0] cpu_addr;
    logic [31:0] cpu_wr_data;
    logic [31:0] cpu_rd_data;
    logic        busy;
    logic        err;
    logic        bus_req_;
    logic        bus_grnt_;
    logic [29:0] bus_addr;
    logic        bus_as_;
    logic        bus_rw;
    logic [31:0] bus_wr_data;
    logic [31:0] bus_rd_data;
    logic        bus_rdy_;

    bus_master_if #(.TIMEOUT(TMO), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .cpu_as_(cpu_as_), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
        .cpu_wr_data(cpu_wr_data), .cpu_rd_data(cpu_rd_data),
        .busy(busy), .err(err), .bus_req_(bus_req_), .bus_grnt_(bus_grnt_),
        .bus_addr(bus_addr), .bus_as_(bus_as_), .bus_rw(bus_rw),
        .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_asrt = 0;
    int n_fail = 0;
    int n_txn  = 0;
    logic [32:0] sb_q[$];   // {expected cpu_rd_data, expected err pulse}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_asrt++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: a completion is the only cycle with bus_req_ low and busy low
    initial begin
        logic [32:0] e;
        bit err_pend;
        bit err_exp;
        err_pend = 0;
        err_exp  = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                err_pend = 0;
            end else begin
                if (err_pend) begin
                    check("err_pulse", err, err_exp);
                    err_pend = 0;
                end else if (err) begin
                    check("err_spurious", err, 1'b0);
                end
                if (!bus_req_ && !busy) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_completion", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        n_txn++;
                        check("cpu_rd_data", cpu_rd_data, e[32:1]);
                        err_pend = 1;
                        err_exp  = e[0];
                        $display("txn %0d: rd_data=%h err_expected=%0b", n_txn, cpu_rd_data, e[0]);
                    end
                end
            end
        end
    end

    // One complete access: req_cycles REQ cycles (grant on the last), nwait
    // slave wait states (nwait >= TMO means no rdy_ at all), nstall WAIT cycles.
    task automatic run_access(input logic rw, input logic [29:0] addr, input logic [31:0] wd,
                              input logic [31:0] rd, input int req_cycles, input int nwait,
                              input int nstall, input bit fl);
        bit          tmo;
        int          n_acc;
        logic [31:0] exp_rd;
        tmo    = (nwait >= TMO);
        n_acc  = tmo ? TMO : nwait + 1;
        exp_rd = tmo ? 32'h0 : (rw ? rd : 32'h0);
        sb_q.push_back({exp_rd, tmo});
        cpu_as_ = 1'b0; cpu_rw = rw; cpu_addr = addr; cpu_wr_data = wd;
        bus_rd_data = rd;
        @(negedge clk);
        check("idle_busy", busy, 1'b1);
        tick;
        for (int i = 0; i < req_cycles; i++) begin
            bus_grnt_ = (i == req_cycles - 1) ? 1'b0 : 1'b1;
            @(negedge clk);
            check("req_bus_req_", bus_req_, 1'b0);
            check("req_bus_as_", bus_as_, 1'b1);
            check("req_busy", busy, 1'b1);
            check("req_addr", bus_addr, addr);
            check("req_rw", bus_rw, rw);
            check("req_wr_data", bus_wr_data, wd);
            tick;
        end
        bus_grnt_ = 1'b1;
        for (int i = 0; i < n_acc; i++) begin
            bus_rdy_ = (!tmo && i == nwait) ? 1'b0 : 1'b1;
            stall    = (nstall > 0);
            flush    = fl;
            @(negedge clk);
            check("acc_bus_as_", bus_as_, (i == 0) ? 1'b0 : 1'b1);
            check("acc_bus_req_", bus_req_, 1'b0);
            check("acc_busy", busy, (i == n_acc - 1) ? 1'b0 : 1'b1);
            check("acc_addr", bus_addr, addr);
            check("acc_rw", bus_rw, rw);
            check("acc_wr_data", bus_wr_data, wd);
            tick;
        end
        bus_rdy_ = 1'b1;
        flush    = 1'b0;
        if (nstall == 0) cpu_as_ = 1'b1;
        for (int k = 0; k < nstall; k++) begin
            stall = (k < nstall - 1);
            @(negedge clk);
            check("wait_state", dut.state_q, 2'd3);
            check("wait_busy", busy, 1'b0);
            check("wait_rd_data", cpu_rd_data, exp_rd);
            check("wait_bus_req_", bus_req_, 1'b1);
            tick;
        end
        cpu_as_ = 1'b1;
        stall   = 1'b0;
        @(negedge clk);
        check("post_bus_req_", bus_req_, 1'b1);
        check("post_bus_as_", bus_as_, 1'b1);
        check("post_busy", busy, 1'b0);
        check("post_rd_buf", cpu_rd_data, exp_rd);
        check("post_addr_hold", bus_addr, addr);
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; cpu_as_ = 1'b1; cpu_rw = 1'b1;
        cpu_addr = '0; cpu_wr_data = '0; bus_grnt_ = 1'b1; bus_rd_data = '0; bus_rdy_ = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_bus_req_", bus_req_, 1'b1);
        check("rst_bus_as_", bus_as_, 1'b1);
        check("rst_bus_rw", bus_rw, 1'b1);
        check("rst_bus_addr", bus_addr, 30'h0);
        check("rst_bus_wr_data", bus_wr_data, 32'h0);
        check("rst_err", err, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_rd_data", cpu_rd_data, 32'h0);
        tick;

        // read zero-wait, write with 4 REQ cycles and 2 wait states, stalled read
        run_access(1'b1, 30'h100, 32'h0, 32'hDEADBEEF, 1, 0, 0, 1'b0);
        run_access(1'b0, 30'h200, 32'h12345678, 32'hCAFEF00D, 4, 2, 0, 1'b0);
        run_access(1'b1, 30'h300, 32'h0, 32'hA5A5A5A5, 1, 1, 3, 1'b0);
        // timeout, then rdy_ exactly on the last counted cycle
        run_access(1'b1, 30'h0ABC, 32'h0, 32'hFFFF0000, 1, TMO, 0, 1'b0);
        run_access(1'b1, 30'h0ABD, 32'h0, 32'h13579BDF, 2, TMO - 1, 0, 1'b0);
        // flush during ACCESS is ignored
        run_access(1'b1, 30'h0440, 32'h0, 32'h2468ACE0, 1, 1, 0, 1'b1);

        // flush wins over a same-cycle grant in REQ
        cpu_as_ = 1'b0; cpu_rw = 1'b1; cpu_addr = 30'h555;
        tick;
        flush = 1'b1; bus_grnt_ = 1'b0;
        @(negedge clk);
        check("flush_req_busy", busy, 1'b1);
        tick;
        @(negedge clk);
        check("flush_bus_as_", bus_as_, 1'b1);
        check("flush_bus_req_", bus_req_, 1'b1);
        check("flush_state", dut.state_q, 2'd0);
        check("flush_idle_busy", busy, 1'b0);
        tick;
        flush = 1'b0; bus_grnt_ = 1'b1; cpu_as_ = 1'b1;
        @(negedge clk);
        check("flush_no_req", bus_req_, 1'b1);
        tick;

        // synchronous reset mid-ACCESS
        cpu_as_ = 1'b0; cpu_rw = 1'b0; cpu_addr = 30'h3FF; cpu_wr_data = 32'h77777777;
        tick;
        bus_grnt_ = 1'b0;
        tick;
        bus_grnt_ = 1'b1;
        @(negedge clk);
        check("pre_rst_bus_as_", bus_as_, 1'b0);
        reset = 1'b1;
        tick;
        reset = 1'b0; cpu_as_ = 1'b1;
        @(negedge clk);
        check("mid_rst_bus_req_", bus_req_, 1'b1);
        check("mid_rst_bus_as_", bus_as_, 1'b1);
        check("mid_rst_bus_rw", bus_rw, 1'b1);
        check("mid_rst_bus_addr", bus_addr, 30'h0);
        check("mid_rst_wr_data", bus_wr_data, 32'h0);
        check("mid_rst_err", err, 1'b0);
        check("mid_rst_rd_data", cpu_rd_data, 32'h0);
        bus_rdy_ = 1'b0; bus_rd_data = 32'h99999999;
        #1;
        check("late_rdy_busy", busy, 1'b0);
        tick;
        bus_rdy_ = 1'b1;
        @(negedge clk);
        check("late_rdy_err", err, 1'b0);
        check("late_rdy_state", dut.state_q, 2'd0);
        check("late_rdy_rd_data", cpu_rd_data, 32'h0);
        repeat (3) tick;

        check("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
